// File: rtl/fig_04b_prefix_ctrl_pkg.sv
// Shared opcode constants and classification types for the GSU prefix tracker.
package fig_04b_prefix_ctrl_pkg;

  // High nibbles that identify the register-latching prefixes.
  localparam logic [3:0] OP_TO   = 4'h1;
  localparam logic [3:0] OP_WITH = 4'h2;
  localparam logic [3:0] OP_FROM = 4'hB;

  // Full opcodes of the ALT prefixes; their low two bits are the ALT value.
  localparam logic [7:0] OP_ALT1 = 8'h3D;
  localparam logic [7:0] OP_ALT2 = 8'h3E;
  localparam logic [7:0] OP_ALT3 = 8'h3F;

  // Inclusive branch opcode range.
  localparam logic [7:0] OP_BR_LO = 8'h05;
  localparam logic [7:0] OP_BR_HI = 8'h0F;

  // Prefix-state field widths not tied to the register index parameter.
  localparam int ALT_BITS = 2;

  typedef enum logic [2:0] {
    CLS_TO,
    CLS_WITH,
    CLS_FROM,
    CLS_ALT,
    CLS_BRANCH,
    CLS_PLAIN
  } op_class_e;

  function automatic logic is_branch(input logic [7:0] op);
    return (op >= OP_BR_LO) && (op <= OP_BR_HI);
  endfunction

endpackage

// File: rtl/fig_04b_prefix_decode.sv
// Combinational opcode classifier: given the current prefix state, produces the
// opcode class, the next prefix state and the state the exec stage should see.
module fig_04b_prefix_decode
  import fig_04b_prefix_ctrl_pkg::*;
#(
  parameter int REG_BITS    = 4,
  parameter int BRANCH_KEEP = 1
) (
  input  logic [7:0]          opcode,
  input  logic [REG_BITS-1:0] cur_sreg,
  input  logic [REG_BITS-1:0] cur_dreg,
  input  logic                cur_b,
  input  logic [ALT_BITS-1:0] cur_alt,
  output op_class_e           op_class,
  output logic [REG_BITS-1:0] nxt_sreg,
  output logic [REG_BITS-1:0] nxt_dreg,
  output logic                nxt_b,
  output logic [ALT_BITS-1:0] nxt_alt,
  output logic [REG_BITS-1:0] exe_sreg,
  output logic [REG_BITS-1:0] exe_dreg,
  output logic                exe_b,
  output logic [ALT_BITS-1:0] exe_alt,
  output logic                is_to,
  output logic                is_from,
  output logic                resflags
);

  logic [3:0]          hi;
  logic [REG_BITS-1:0] n;

  assign hi = opcode[7:4];
  assign n  = REG_BITS'(opcode[3:0]);

  // Classify the opcode; with B set, 0x1n/0xBn are MOVE/MOVES, not prefixes.
  always_comb begin
    op_class = CLS_PLAIN;
    if (hi == OP_TO && !cur_b)
      op_class = CLS_TO;
    else if (hi == OP_WITH)
      op_class = CLS_WITH;
    else if (hi == OP_FROM && !cur_b)
      op_class = CLS_FROM;
    else if (opcode == OP_ALT1 || opcode == OP_ALT2 || opcode == OP_ALT3)
      op_class = CLS_ALT;
    else if (is_branch(opcode) && BRANCH_KEEP != 0)
      op_class = CLS_BRANCH;
  end

  // Next state per class; prefixes expose their own update, plain ops expose the old state.
  always_comb begin
    nxt_sreg = cur_sreg;
    nxt_dreg = cur_dreg;
    nxt_b    = cur_b;
    nxt_alt  = cur_alt;
    is_to    = 1'b0;
    is_from  = 1'b0;
    resflags = 1'b0;
    case (op_class)
      CLS_TO: begin
        nxt_dreg = n;
        is_to    = 1'b1;
      end
      CLS_WITH: begin
        nxt_sreg = n;
        nxt_dreg = n;
        nxt_b    = 1'b1;
      end
      CLS_FROM: begin
        nxt_sreg = n;
        is_from  = 1'b1;
      end
      CLS_ALT: begin
        nxt_alt = opcode[ALT_BITS-1:0];
      end
      CLS_BRANCH: begin
        nxt_sreg = cur_sreg;
      end
      default: begin
        nxt_sreg = '0;
        nxt_dreg = '0;
        nxt_b    = 1'b0;
        nxt_alt  = '0;
        resflags = 1'b1;
      end
    endcase
  end

  assign exe_sreg = resflags ? cur_sreg : nxt_sreg;
  assign exe_dreg = resflags ? cur_dreg : nxt_dreg;
  assign exe_b    = resflags ? cur_b    : nxt_b;
  assign exe_alt  = resflags ? cur_alt  : nxt_alt;

endmodule

// File: rtl/fig_04b_prefix_ctrl.sv
// GSU instruction-prefix tracker: holds TO/FROM/WITH/ALT state and presents
// registered exec-stage controls one cycle after each accepted opcode.
module fig_04b_prefix_ctrl
  import fig_04b_prefix_ctrl_pkg::*;
#(
  parameter int REG_BITS    = 4,
  parameter int BRANCH_KEEP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic [7:0]          opcode,
  input  logic                flush,
  output logic                exec_valid,
  output logic [3:0]          instr,
  output logic [3:0]          ha,
  output logic [1:0]          alt,
  output logic                to,
  output logic                from,
  output logic                ssel,
  output logic                dsel,
  output logic [REG_BITS-1:0] sreg,
  output logic [REG_BITS-1:0] dreg,
  output logic                b_flag,
  output logic                resflags
);

  logic [REG_BITS-1:0] st_sreg, st_dreg;
  logic                st_b;
  logic [ALT_BITS-1:0] st_alt;

  op_class_e           op_class;
  logic [REG_BITS-1:0] nxt_sreg, nxt_dreg, exe_sreg, exe_dreg;
  logic                nxt_b, exe_b;
  logic [ALT_BITS-1:0] nxt_alt, exe_alt;
  logic                dec_to, dec_from, dec_res;
  logic                accept;

  assign accept = op_valid && !flush;

  fig_04b_prefix_decode #(
    .REG_BITS   (REG_BITS),
    .BRANCH_KEEP(BRANCH_KEEP)
  ) u_decode (
    .opcode  (opcode),
    .cur_sreg(st_sreg),
    .cur_dreg(st_dreg),
    .cur_b   (st_b),
    .cur_alt (st_alt),
    .op_class(op_class),
    .nxt_sreg(nxt_sreg),
    .nxt_dreg(nxt_dreg),
    .nxt_b   (nxt_b),
    .nxt_alt (nxt_alt),
    .exe_sreg(exe_sreg),
    .exe_dreg(exe_dreg),
    .exe_b   (exe_b),
    .exe_alt (exe_alt),
    .is_to   (dec_to),
    .is_from (dec_from),
    .resflags(dec_res)
  );

  // Prefix state register: flush clears, an accepted opcode loads the decoded next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_sreg <= '0;
      st_dreg <= '0;
      st_b    <= 1'b0;
      st_alt  <= '0;
    end else if (flush) begin
      st_sreg <= '0;
      st_dreg <= '0;
      st_b    <= 1'b0;
      st_alt  <= '0;
    end else if (op_valid) begin
      st_sreg <= nxt_sreg;
      st_dreg <= nxt_dreg;
      st_b    <= nxt_b;
      st_alt  <= nxt_alt;
    end
  end

  // Exec-stage register: valid pulses per accepted opcode, payload holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_valid <= 1'b0;
      instr      <= '0;
      ha         <= '0;
      alt        <= '0;
      to         <= 1'b0;
      from       <= 1'b0;
      ssel       <= 1'b0;
      dsel       <= 1'b0;
      sreg       <= '0;
      dreg       <= '0;
      b_flag     <= 1'b0;
      resflags   <= 1'b0;
    end else begin
      exec_valid <= accept;
      if (accept) begin
        instr    <= opcode[7:4];
        ha       <= opcode[3:0];
        alt      <= exe_alt;
        to       <= dec_to;
        from     <= dec_from;
        ssel     <= (exe_sreg != '0) || exe_b;
        dsel     <= (exe_dreg != '0) || exe_b;
        sreg     <= exe_sreg;
        dreg     <= exe_dreg;
        b_flag   <= exe_b;
        resflags <= dec_res;
      end
    end
  end

endmodule

// File: tb/tb_fig_04b_prefix_ctrl.sv
// Scoreboard bench: two instances (branches keep / branches clear) share stimulus;
// a reference model pushes expected exec words, monitors pop and compare.
module tb_fig_04b_prefix_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] opcode = 8'h00;

  logic       k_ev, d_ev;
  logic [3:0] k_instr, k_ha, k_sreg, k_dreg, d_instr, d_ha, d_sreg, d_dreg;
  logic [1:0] k_alt, d_alt;
  logic       k_to, k_from, k_ssel, k_dsel, k_b, k_res;
  logic       d_to, d_from, d_ssel, d_dsel, d_b, d_res;

  int n_checks = 0;
  int n_fail = 0;

  logic [23:0] q_keep[$];
  logic [23:0] q_drop[$];
  logic [23:0] last_keep = '0;
  logic [23:0] last_drop = '0;

  logic [3:0] m_s[2];
  logic [3:0] m_d[2];
  logic       m_b[2];
  logic [1:0] m_a[2];

  fig_04b_prefix_ctrl #(.REG_BITS(4), .BRANCH_KEEP(1)) u_keep (
    .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode), .flush(flush),
    .exec_valid(k_ev), .instr(k_instr), .ha(k_ha), .alt(k_alt), .to(k_to), .from(k_from),
    .ssel(k_ssel), .dsel(k_dsel), .sreg(k_sreg), .dreg(k_dreg), .b_flag(k_b), .resflags(k_res)
  );

  fig_04b_prefix_ctrl #(.REG_BITS(4), .BRANCH_KEEP(0)) u_drop (
    .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode), .flush(flush),
    .exec_valid(d_ev), .instr(d_instr), .ha(d_ha), .alt(d_alt), .to(d_to), .from(d_from),
    .ssel(d_ssel), .dsel(d_dsel), .sreg(d_sreg), .dreg(d_dreg), .b_flag(d_b), .resflags(d_res)
  );

  always #5 clk = ~clk;

  wire [23:0] k_vec = {k_instr, k_ha, k_alt, k_to, k_from, k_ssel, k_dsel, k_sreg, k_dreg, k_b, k_res};
  wire [23:0] d_vec = {d_instr, d_ha, d_alt, d_to, d_from, d_ssel, d_dsel, d_sreg, d_dreg, d_b, d_res};

  task automatic checkOutput(input string name, input logic [24:0] exp, input logic [24:0] got);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got {valid,exec}=%h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 2; i++) begin
      m_s[i] = '0; m_d[i] = '0; m_b[i] = 1'b0; m_a[i] = '0;
    end
  endtask

  // Reference model: instance 0 keeps prefixes across branches, instance 1 does not.
  task automatic modelOp(input int i, input logic [7:0] op, output logic [23:0] exp);
    logic [3:0] hi, n;
    logic [7:0] alt_sel;
    logic t, f, r;
    hi = op[7:4];
    n = op[3:0];
    t = 1'b0; f = 1'b0; r = 1'b0;
    if (hi == 4'h1 && !m_b[i]) begin
      m_d[i] = n; t = 1'b1;
    end else if (hi == 4'h2) begin
      m_s[i] = n; m_d[i] = n; m_b[i] = 1'b1;
    end else if (hi == 4'hB && !m_b[i]) begin
      m_s[i] = n; f = 1'b1;
    end else if (op >= 8'h3D && op <= 8'h3F) begin
      alt_sel = op - 8'h3C;
      m_a[i] = alt_sel[1:0];
    end else if (op >= 8'h05 && op <= 8'h0F && i == 0) begin
      r = 1'b0;
    end else begin
      r = 1'b1;
    end
    exp = {hi, n, m_a[i], t, f, (m_s[i] != 0) || m_b[i], (m_d[i] != 0) || m_b[i],
           m_s[i], m_d[i], m_b[i], r};
    if (r) begin
      m_s[i] = '0; m_d[i] = '0; m_b[i] = 1'b0; m_a[i] = '0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic fl);
    logic [23:0] e;
    @(posedge clk);
    #1;
    op_valid = v;
    opcode = op;
    flush = fl;
    if (fl) begin
      clearModel();
    end else if (v) begin
      modelOp(0, op, e); q_keep.push_back(e);
      modelOp(1, op, e); q_drop.push_back(e);
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    op_valid = 1'b0;
    flush = 1'b0;
    q_keep.delete();
    q_drop.delete();
    clearModel();
    #1;
    checkOutput("reset_async_keep", 25'h0, {k_ev, k_vec});
    checkOutput("reset_async_drop", 25'h0, {d_ev, d_vec});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [7:0] randOp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return {4'h1, r[3:0]};
      1: return {4'h2, r[3:0]};
      2: return {4'hB, r[3:0]};
      3: return 8'h3D + 8'($urandom_range(0, 2));
      4: return 8'h05 + 8'($urandom_range(0, 10));
      default: return r[7:0];
    endcase
  endfunction

  // Monitor for the branch-keeping instance.
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset) begin
      checkOutput("reset_keep", 25'h0, {k_ev, k_vec});
      last_keep = '0;
    end else if (k_ev) begin
      if (q_keep.size() == 0) begin
        checkOutput("spurious_exec_keep", {1'b0, last_keep}, {k_ev, k_vec});
      end else begin
        e = q_keep.pop_front();
        checkOutput("exec_keep", {1'b1, e}, {k_ev, k_vec});
        last_keep = e;
      end
    end else begin
      checkOutput("hold_keep", {1'b0, last_keep}, {k_ev, k_vec});
    end
  end

  // Monitor for the branch-clearing instance.
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset) begin
      checkOutput("reset_drop", 25'h0, {d_ev, d_vec});
      last_drop = '0;
    end else if (d_ev) begin
      if (q_drop.size() == 0) begin
        checkOutput("spurious_exec_drop", {1'b0, last_drop}, {d_ev, d_vec});
      end else begin
        e = q_drop.pop_front();
        checkOutput("exec_drop", {1'b1, e}, {d_ev, d_vec});
        last_drop = e;
      end
    end else begin
      checkOutput("hold_drop", {1'b0, last_drop}, {d_ev, d_vec});
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] op;
    int r;
    clearModel();
    doReset();

    // TO then FROM accumulate, consumed by a plain op.
    applyStimulus(1, 8'h15, 0);
    applyStimulus(1, 8'hB7, 0);
    applyStimulus(1, 8'h50, 0);
    applyStimulus(1, 8'h50, 0);
    applyStimulus(0, 8'h00, 0);
    // WITH then 0x14 is MOVE.
    applyStimulus(1, 8'h23, 0);
    applyStimulus(1, 8'h14, 0);
    applyStimulus(1, 8'h60, 0);
    // ALT2 overwrites ALT1.
    applyStimulus(1, 8'h3D, 0);
    applyStimulus(1, 8'h3E, 0);
    applyStimulus(1, 8'h60, 0);
    applyStimulus(1, 8'h60, 0);
    // Branch between TO and a plain op.
    applyStimulus(1, 8'h12, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(1, 8'h08, 0);
    applyStimulus(1, 8'h50, 0);
    // Flush with a valid opcode discards it and clears state.
    applyStimulus(1, 8'h19, 0);
    applyStimulus(1, 8'h50, 1);
    applyStimulus(1, 8'h50, 0);
    // Reset mid-sequence.
    applyStimulus(1, 8'h2A, 0);
    applyStimulus(1, 8'h3F, 0);
    doReset();
    applyStimulus(1, 8'h50, 0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      op = randOp();
      if (r < 2) doReset();
      else if (r < 8) applyStimulus(1'($urandom_range(0, 1)), op, 1'b1);
      else if (r < 25) applyStimulus(1'b0, op, 1'b0);
      else applyStimulus(1'b1, op, 1'b0);
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 0);
    @(posedge clk);
    #1;
    checkOutput("drain_keep", 25'h0, 25'(q_keep.size()));
    checkOutput("drain_drop", 25'h0, 25'(q_drop.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
